// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned MULTU/DIVU unit holding HI/LO and serving MFHI/MFLO reads.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise DIVU completes at once with HI/LO unchanged.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef MULDIV_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_MFHI = 2'b10;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   op_b;
    logic [2*WIDTH-1:0] acc;
    logic               accept;
    logic               last_iter;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

`ifdef MULDIV_DIV_EN
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem_next;
    logic [WIDTH-1:0]   div_quo_next;
`endif

    assign busy    = (state_q == S_MUL)
`ifdef MULDIV_DIV_EN
                   || (state_q == S_DIV)
`endif
                   ;
    assign done    = (state_q == S_DONE);
    assign stall   = start && busy;
    assign rd_data = (op == OP_MFHI) ? hi : lo;

    // Only MULTU/DIVU (op[1]=0) are accepted, and only when no iteration is running.
    assign accept    = start && !op[1] && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // Shift-add step: conditional add into the upper half, then shift {carry, P} right.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_b} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
    // Restoring step; the stored remainder always fits WIDTH bits, so the
    // subtraction only needs the low WIDTH bits of the shifted value.
    assign div_shift    = {rem, quo[WIDTH-1]};
    assign div_ge       = (div_shift >= {1'b0, op_b});
    assign div_rem_next = div_ge ? (div_shift[WIDTH-1:0] - op_b) : div_shift[WIDTH-1:0];
    assign div_quo_next = {quo[WIDTH-2:0], div_ge};
`endif

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
`ifdef MULDIV_DIV_EN
                    state_d = op[0] ? S_DIV : S_MUL;
`else
                    state_d = op[0] ? S_DONE : S_MUL;
`endif
                end
            end
            S_MUL: if (last_iter) state_d = S_DONE;
`ifdef MULDIV_DIV_EN
            S_DIV: if (last_iter) state_d = S_DONE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: all datapath registers are cleared too, so an aborted operation leaves nothing behind.
            state_q <= S_IDLE;
            cnt     <= '0;
            op_b    <= '0;
            acc     <= '0;
            hi      <= '0;
            lo      <= '0;
`ifdef MULDIV_DIV_EN
            rem     <= '0;
            quo     <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt  <= '0;
                op_b <= src_b;
                acc  <= {{WIDTH{1'b0}}, src_a};
`ifdef MULDIV_DIV_EN
                rem  <= '0;
                quo  <= src_a;
`endif
            end else if (state_q == S_MUL) begin
                cnt <= cnt + 1'b1;
                acc <= mul_next;
                if (last_iter) begin
                    hi <= mul_next[2*WIDTH-1:WIDTH];
                    lo <= mul_next[WIDTH-1:0];
                end
`ifdef MULDIV_DIV_EN
            end else if (state_q == S_DIV) begin
                cnt <= cnt + 1'b1;
                rem <= div_rem_next;
                quo <= div_quo_next;
                if (last_iter) begin
                    hi <= div_rem_next;
                    lo <= div_quo_next;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; divider scenarios follow MULDIV_DIV_EN.
module tb_muldiv_unit;

    localparam int W = 32;
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MFHI  = 2'b10;
    localparam logic [1:0] OP_MFLO  = 2'b11;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] src_a, src_b;
    logic         busy, done, stall;
    logic [W-1:0] hi, lo, rd_data;

    int checks   = 0;
    int failures = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .busy    (busy),
        .done    (done),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    // Present a request for one cycle; returns at the negedge after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for done; lat counts cycles since the first busy cycle.
    task automatic wait_done(output int busy_n, output int lat);
        busy_n = 0;
        lat    = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; op = OP_MULTU; src_a = 32'd3; src_b = 32'd3;
        repeat (2) @(negedge clk);
        start = 1'b0; reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    endtask

    task automatic test_mul_max();
        int busy_n, lat;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(busy_n, lat);
        checks++; if (busy_n != 32) begin failures++; $display("FAIL mulmax_busy_cycles got=%0d exp=32", busy_n); end
        checks++; if (lat != 32 || done !== 1'b1) begin failures++; $display("FAIL mulmax_done_latency got=%0d exp=32", lat); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mulmax_busy_in_done got=%b exp=0", busy); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mulmax_hi got=%h exp=fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin failures++; $display("FAIL mulmax_lo got=%h exp=00000001", lo); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL mulmax_done_pulse got=%b exp=0", done); end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div();
        int busy_n, lat;
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(busy_n, lat);
        checks++; if (lat != 32 || busy_n != 32) begin failures++; $display("FAIL div_latency got=%0d/%0d exp=32/32", lat, busy_n); end
        checks++; if (lo !== 32'd14) begin failures++; $display("FAIL div_quot got=%0d exp=14", lo); end
        checks++; if (hi !== 32'd2) begin failures++; $display("FAIL div_rem got=%0d exp=2", hi); end
        start = 1'b1; op = OP_MFLO;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL div_mflo_stall got=%b exp=0", stall); end
        checks++; if (rd_data !== 32'd14) begin failures++; $display("FAIL div_mflo_data got=%0d exp=14", rd_data); end
        start = 1'b0;
        issue(OP_DIVU, 32'd5, 32'd0);
        wait_done(busy_n, lat);
        checks++; if (lat != 32 || busy_n != 32) begin failures++; $display("FAIL div0_latency got=%0d/%0d exp=32/32", lat, busy_n); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div0_quot got=%h exp=ffffffff", lo); end
        checks++; if (hi !== 32'd5) begin failures++; $display("FAIL div0_rem got=%0d exp=5", hi); end
    endtask
`else
    task automatic test_no_div();
        int busy_n, lat;
        issue(OP_MULTU, 32'd3, 32'd3);
        wait_done(busy_n, lat);
        checks++; if (lo !== 32'd9) begin failures++; $display("FAIL nodiv_preload_lo got=%0d exp=9", lo); end
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; src_a = 32'd8; src_b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL nodiv_done got=%b exp=1", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nodiv_busy got=%b exp=0", busy); end
        checks++; if (lo !== 32'd9 || hi !== 32'd0) begin failures++; $display("FAIL nodiv_hilo got=%h/%h exp=0/9", hi, lo); end
        busy_n = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy === 1'b1) busy_n++;
        end
        checks++; if (busy_n != 0 || done !== 1'b0) begin failures++; $display("FAIL nodiv_after busy=%0d done=%b exp=0/0", busy_n, done); end
    endtask
`endif

    task automatic test_mul_stall();
        int stall_n, lat;
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; src_a = 32'd6; src_b = 32'd7;
        @(negedge clk);
        op = OP_MFHI;
        stall_n = 0;
        lat     = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (stall === 1'b1) stall_n++;
            @(negedge clk);
            lat++;
        end
        checks++; if (stall_n != 32) begin failures++; $display("FAIL stall_cycles got=%0d exp=32", stall_n); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL stall_in_done got=%b exp=0", stall); end
        checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL stall_mfhi got=%0d exp=0", rd_data); end
        op = OP_MFLO;
        #1;
        checks++; if (rd_data !== 32'd42) begin failures++; $display("FAIL stall_mflo got=%0d exp=42", rd_data); end
        start = 1'b0;
    endtask

    task automatic test_reset_abort();
        int done_n;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin failures++; $display("FAIL abort_hilo got=%h/%h exp=0/0", hi, lo); end
        done_n = 0;
        repeat (40) begin
            if (done === 1'b1) done_n++;
            @(negedge clk);
        end
        checks++; if (done_n != 0) begin failures++; $display("FAIL abort_done_pulses got=%0d exp=0", done_n); end
    endtask

    task automatic test_back_to_back();
        int busy_n, lat;
        issue(OP_MULTU, 32'd3, 32'd4);
        wait_done(busy_n, lat);
        checks++; if (lo !== 32'd12 || hi !== 32'd0) begin failures++; $display("FAIL b2b_first got=%h/%h exp=0/c", hi, lo); end
        start = 1'b1; op = OP_MULTU; src_a = 32'h0001_0000; src_b = 32'h0003_0005;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL b2b_no_bubble busy=%b done=%b exp=1/0", busy, done); end
        wait_done(busy_n, lat);
        checks++; if (lat != 32) begin failures++; $display("FAIL b2b_latency got=%0d exp=32", lat); end
        checks++; if (hi !== 32'h0000_0003 || lo !== 32'h0005_0000) begin failures++; $display("FAIL b2b_second got=%h/%h exp=3/50000", hi, lo); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = OP_MULTU; src_a = '0; src_b = '0;
        test_reset();
        test_mul_max();
`ifdef MULDIV_DIV_EN
        test_div();
`endif
        test_mul_stall();
        test_reset_abort();
        test_back_to_back();
`ifndef MULDIV_DIV_EN
        test_no_div();
`endif
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
